// File: rtl/l15_simple_transducer.sv
// ----------------------------------------------------------------------------
// l15_simple_transducer
//
// Single-outstanding request initiator for the core side of the L1.5
// transducer interface. A simple valid/ready load/store port is turned into
// transducer_l15_* requests. The L1.5 ack is handled, and the
// l15_transducer_* response stream is consumed. Every response is
// acknowledged in the cycle it appears. Responses that do not complete the
// outstanding request (invalidations, strays, type mismatches) are discarded
// and counted in a saturating counter.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_val/req_rdy             upstream request handshake (ready only in IDLE)
//   req_we/addr/size/nc/wdata   upstream request fields (store data right-aligned)
//   resp_val/rdata/err          one-cycle completion pulse with load data / error
//   drop_cnt                    saturating count of discarded responses
//   transducer_l15_*            request to the L1.5 (unused fields tied to 0)
//   l15_transducer_ack          L1.5 accepted the request
//   l15_transducer_val/...      response stream from the L1.5
//   transducer_l15_req_ack      response consumed (combinational)
// ----------------------------------------------------------------------------
module l15_simple_transducer #(
    parameter int DROP_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_val,
    output logic                  req_rdy,
    input  logic                  req_we,
    input  logic [39:0]           req_addr,
    input  logic [2:0]            req_size,
    input  logic                  req_nc,
    input  logic [63:0]           req_wdata,
    output logic                  resp_val,
    output logic [63:0]           resp_rdata,
    output logic [1:0]            resp_err,
    output logic [DROP_CNT_W-1:0] drop_cnt,
    output logic                  transducer_l15_val,
    output logic [4:0]            transducer_l15_rqtype,
    output logic                  transducer_l15_nc,
    output logic [2:0]            transducer_l15_size,
    output logic [39:0]           transducer_l15_address,
    output logic [63:0]           transducer_l15_data,
    output logic [3:0]            transducer_l15_amo_op,
    output logic                  transducer_l15_threadid,
    output logic                  transducer_l15_prefetch,
    output logic                  transducer_l15_invalidate_cacheline,
    output logic                  transducer_l15_blockstore,
    output logic                  transducer_l15_blockinitstore,
    output logic [1:0]            transducer_l15_l1rplway,
    output logic [63:0]           transducer_l15_data_next_entry,
    output logic [32:0]           transducer_l15_csm_data,
    input  logic                  l15_transducer_ack,
    input  logic                  l15_transducer_val,
    input  logic [3:0]            l15_transducer_returntype,
    input  logic [1:0]            l15_transducer_error,
    input  logic [63:0]           l15_transducer_data_0,
    input  logic [63:0]           l15_transducer_data_1,
    output logic                  transducer_l15_req_ack
);

    localparam logic [4:0] LOAD_RQ  = 5'b00000;
    localparam logic [4:0] STORE_RQ = 5'b00001;
    localparam logic [3:0] LOAD_RET = 4'b0000;
    localparam logic [3:0] ST_ACK   = 4'b0100;
    localparam logic [DROP_CNT_W-1:0] DROP_ONE = 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RESP
    } state_t;

    state_t                r_state;
    logic                  r_req_rdy;
    logic                  r_we;
    logic [3:0]            r_exp_type;
    logic                  r_tl_val;
    logic [4:0]            r_tl_rqtype;
    logic                  r_tl_nc;
    logic [2:0]            r_tl_size;
    logic [39:0]           r_tl_address;
    logic [63:0]           r_tl_data;
    logic                  r_resp_val;
    logic [63:0]           r_resp_rdata;
    logic [1:0]            r_resp_err;
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    logic w_match;
    logic w_complete;
    logic w_drop;

    // The L1.5 expects narrow store data replicated across the 8-byte lane.
    function automatic logic [63:0] replicate(input logic [2:0] size,
                                              input logic [63:0] data);
        logic [63:0] result;
        case (size)
            3'd0:    result = {8{data[7:0]}};
            3'd1:    result = {4{data[15:0]}};
            3'd2:    result = {2{data[31:0]}};
            default: result = data;
        endcase
        return result;
    endfunction

    // A response completes the request only in WAIT_RESP, or in REQ when the
    // ack lands in the same cycle. Any other response is dropped.
    assign w_match    = l15_transducer_val && (l15_transducer_returntype == r_exp_type);
    assign w_complete = w_match &&
                        ((r_state == WAIT_RESP) || ((r_state == REQ) && l15_transducer_ack));
    assign w_drop     = l15_transducer_val && !w_complete;

    // Main control: the request/response state machine with all registered
    // outputs. resp_val defaults low each cycle so that it is a single pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_req_rdy    <= 1'b1;
            r_we         <= 1'b0;
            r_exp_type   <= 4'd0;
            r_tl_val     <= 1'b0;
            r_tl_rqtype  <= 5'd0;
            r_tl_nc      <= 1'b0;
            r_tl_size    <= 3'd0;
            r_tl_address <= 40'd0;
            r_tl_data    <= 64'd0;
            r_resp_val   <= 1'b0;
            r_resp_rdata <= 64'd0;
            r_resp_err   <= 2'd0;
            r_drop_cnt   <= '0;
        end else begin
            r_resp_val <= 1'b0;

            if (w_drop && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + DROP_ONE;
            end

            if (w_complete) begin
                r_resp_val   <= 1'b1;
                r_resp_err   <= l15_transducer_error;
                r_resp_rdata <= r_we ? 64'd0 :
                                (r_tl_address[3] ? l15_transducer_data_1
                                                 : l15_transducer_data_0);
            end

            case (r_state)
                IDLE: begin
                    if (req_val) begin
                        r_we         <= req_we;
                        r_exp_type   <= req_we ? ST_ACK : LOAD_RET;
                        r_tl_val     <= 1'b1;
                        r_tl_rqtype  <= req_we ? STORE_RQ : LOAD_RQ;
                        r_tl_nc      <= req_nc;
                        r_tl_size    <= req_size;
                        r_tl_address <= req_addr;
                        r_tl_data    <= req_we ? replicate(req_size, req_wdata) : 64'd0;
                        r_req_rdy    <= 1'b0;
                        r_state      <= REQ;
                    end
                end
                REQ: begin
                    if (l15_transducer_ack) begin
                        r_tl_val <= 1'b0;
                        if (w_complete) begin
                            r_req_rdy <= 1'b1;
                            r_state   <= IDLE;
                        end else begin
                            r_state <= WAIT_RESP;
                        end
                    end
                end
                WAIT_RESP: begin
                    if (w_complete) begin
                        r_req_rdy <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_req_rdy <= 1'b1;
                    r_tl_val  <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign req_rdy                = r_req_rdy;
    assign resp_val               = r_resp_val;
    assign resp_rdata             = r_resp_rdata;
    assign resp_err               = r_resp_err;
    assign drop_cnt               = r_drop_cnt;
    assign transducer_l15_val     = r_tl_val;
    assign transducer_l15_rqtype  = r_tl_rqtype;
    assign transducer_l15_nc      = r_tl_nc;
    assign transducer_l15_size    = r_tl_size;
    assign transducer_l15_address = r_tl_address;
    assign transducer_l15_data    = r_tl_data;

    // Every response is consumed the cycle it appears, whatever the state.
    assign transducer_l15_req_ack = l15_transducer_val;

    assign transducer_l15_amo_op               = 4'd0;
    assign transducer_l15_threadid             = 1'b0;
    assign transducer_l15_prefetch             = 1'b0;
    assign transducer_l15_invalidate_cacheline = 1'b0;
    assign transducer_l15_blockstore           = 1'b0;
    assign transducer_l15_blockinitstore       = 1'b0;
    assign transducer_l15_l1rplway             = 2'd0;
    assign transducer_l15_data_next_entry      = 64'd0;
    assign transducer_l15_csm_data             = 33'd0;

endmodule

// File: tb/tb_l15_simple_transducer.sv
// ----------------------------------------------------------------------------
// tb_l15_simple_transducer
//
// Self-checking bench for l15_simple_transducer. Each scenario task drives
// the upstream port and plays the L1.5 side cycle by cycle. Expected
// completions ({rdata, err}) are pushed to a scoreboard queue when the
// matching response is driven, and they are popped when resp_val is seen.
// ----------------------------------------------------------------------------
module tb_l15_simple_transducer;

    logic        clk;
    logic        rst_n;
    logic        req_val;
    logic        req_rdy;
    logic        req_we;
    logic [39:0] req_addr;
    logic [2:0]  req_size;
    logic        req_nc;
    logic [63:0] req_wdata;
    logic        resp_val;
    logic [63:0] resp_rdata;
    logic [1:0]  resp_err;
    logic [7:0]  drop_cnt;
    logic        tl_val;
    logic [4:0]  tl_rqtype;
    logic        tl_nc;
    logic [2:0]  tl_size;
    logic [39:0] tl_address;
    logic [63:0] tl_data;
    logic [3:0]  tl_amo_op;
    logic        tl_threadid;
    logic        tl_prefetch;
    logic        tl_inv;
    logic        tl_blockstore;
    logic        tl_blockinitstore;
    logic [1:0]  tl_l1rplway;
    logic [63:0] tl_data_next;
    logic [32:0] tl_csm;
    logic        l15_ack;
    logic        l15_val;
    logic [3:0]  l15_rtype;
    logic [1:0]  l15_err;
    logic [63:0] l15_data0;
    logic [63:0] l15_data1;
    logic        req_ack;

    int          nCompared;
    int          nMismatched;
    int          expDrop;
    logic [65:0] sbQ[$];
    logic [65:0] sbExp;

    l15_simple_transducer #(.DROP_CNT_W(8)) dut (
        .clk                                 (clk),
        .rst_n                               (rst_n),
        .req_val                             (req_val),
        .req_rdy                             (req_rdy),
        .req_we                              (req_we),
        .req_addr                            (req_addr),
        .req_size                            (req_size),
        .req_nc                              (req_nc),
        .req_wdata                           (req_wdata),
        .resp_val                            (resp_val),
        .resp_rdata                          (resp_rdata),
        .resp_err                            (resp_err),
        .drop_cnt                            (drop_cnt),
        .transducer_l15_val                  (tl_val),
        .transducer_l15_rqtype               (tl_rqtype),
        .transducer_l15_nc                   (tl_nc),
        .transducer_l15_size                 (tl_size),
        .transducer_l15_address              (tl_address),
        .transducer_l15_data                 (tl_data),
        .transducer_l15_amo_op               (tl_amo_op),
        .transducer_l15_threadid             (tl_threadid),
        .transducer_l15_prefetch             (tl_prefetch),
        .transducer_l15_invalidate_cacheline (tl_inv),
        .transducer_l15_blockstore           (tl_blockstore),
        .transducer_l15_blockinitstore       (tl_blockinitstore),
        .transducer_l15_l1rplway             (tl_l1rplway),
        .transducer_l15_data_next_entry      (tl_data_next),
        .transducer_l15_csm_data             (tl_csm),
        .l15_transducer_ack                  (l15_ack),
        .l15_transducer_val                  (l15_val),
        .l15_transducer_returntype           (l15_rtype),
        .l15_transducer_error                (l15_err),
        .l15_transducer_data_0               (l15_data0),
        .l15_transducer_data_1               (l15_data1),
        .transducer_l15_req_ack              (req_ack)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to 1 ns after the next rising edge: outputs are sampled and
    // inputs changed there, away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset values of every output, including the tied-off request fields.
    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        nCompared++; if (req_rdy !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset_req_rdy: got %b expected 1", req_rdy); end
        nCompared++; if (tl_val !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_tl_val: got %b expected 0", tl_val); end
        nCompared++; if ({resp_val, resp_rdata, resp_err} !== 67'd0) begin nMismatched++; $display("[TB] FAIL reset_resp: got val=%b rdata=%h err=%b expected all 0", resp_val, resp_rdata, resp_err); end
        nCompared++; if (drop_cnt !== 8'd0) begin nMismatched++; $display("[TB] FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
        nCompared++; if ({tl_rqtype, tl_nc, tl_size, tl_address, tl_data} !== 113'd0) begin nMismatched++; $display("[TB] FAIL reset_tl_fields: got rq=%h addr=%h data=%h expected 0", tl_rqtype, tl_address, tl_data); end
        nCompared++; if ({tl_amo_op, tl_threadid, tl_prefetch, tl_inv, tl_blockstore, tl_blockinitstore, tl_l1rplway, tl_data_next, tl_csm} !== 108'd0) begin nMismatched++; $display("[TB] FAIL reset_tieoffs: got nonzero expected 0"); end
        nCompared++; if (req_ack !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_req_ack: got %b expected 0", req_ack); end
        @(negedge clk);
        rst_n = 1'b1;
        expDrop = 0;
        tick();
    endtask

    // 8-byte load at 0x1008, ack at T+3, LOAD_RET at T+6, upper half selected.
    task automatic test_load();
        req_val = 1'b1; req_we = 1'b0; req_addr = 40'h00_0000_1008; req_size = 3'd3; req_nc = 1'b0; req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();                                   // T+1
        req_val = 1'b0;
        nCompared++; if (tl_val !== 1'b1) begin nMismatched++; $display("[TB] FAIL load_val_t1: got %b expected 1", tl_val); end
        nCompared++; if (tl_rqtype !== 5'd0) begin nMismatched++; $display("[TB] FAIL load_rqtype: got %h expected 00", tl_rqtype); end
        nCompared++; if (tl_address !== 40'h00_0000_1008) begin nMismatched++; $display("[TB] FAIL load_addr: got %h expected 0000001008", tl_address); end
        nCompared++; if (tl_data !== 64'd0) begin nMismatched++; $display("[TB] FAIL load_data_zero: got %h expected 0", tl_data); end
        nCompared++; if (req_rdy !== 1'b0) begin nMismatched++; $display("[TB] FAIL load_rdy_busy: got %b expected 0", req_rdy); end
        tick();                                   // T+2
        tick();                                   // T+3
        nCompared++; if (tl_val !== 1'b1) begin nMismatched++; $display("[TB] FAIL load_val_t3: got %b expected 1", tl_val); end
        l15_ack = 1'b1;
        tick();                                   // T+4
        l15_ack = 1'b0;
        nCompared++; if (tl_val !== 1'b0) begin nMismatched++; $display("[TB] FAIL load_val_t4: got %b expected 0", tl_val); end
        tick();                                   // T+5
        tick();                                   // T+6
        l15_val = 1'b1; l15_rtype = 4'b0000; l15_err = 2'b00;
        l15_data0 = 64'h1111_1111_1111_1111; l15_data1 = 64'hAAAA_BBBB_CCCC_DDDD;
        sbQ.push_back({64'hAAAA_BBBB_CCCC_DDDD, 2'b00});
        #1;
        nCompared++; if (req_ack !== 1'b1) begin nMismatched++; $display("[TB] FAIL load_req_ack: got %b expected 1", req_ack); end
        nCompared++; if (resp_val !== 1'b0) begin nMismatched++; $display("[TB] FAIL load_resp_early: got %b expected 0", resp_val); end
        tick();                                   // T+7
        l15_val = 1'b0;
        nCompared++;
        if (resp_val !== 1'b1) begin
            nMismatched++; $display("[TB] FAIL load_resp_val: got %b expected 1", resp_val);
        end else if (sbQ.size() == 0) begin
            nMismatched++; $display("[TB] FAIL load_sb_empty: got resp with empty scoreboard expected entry");
        end else begin
            sbExp = sbQ.pop_front();
            if ({resp_rdata, resp_err} !== sbExp) begin nMismatched++; $display("[TB] FAIL load_rdata: got %h/%b expected %h/%b", resp_rdata, resp_err, sbExp[65:2], sbExp[1:0]); end
        end
        nCompared++; if (req_rdy !== 1'b1) begin nMismatched++; $display("[TB] FAIL load_rdy_done: got %b expected 1", req_rdy); end
        nCompared++; if (drop_cnt !== expDrop[7:0]) begin nMismatched++; $display("[TB] FAIL load_drop: got %0d expected %0d", drop_cnt, expDrop); end
        tick();                                   // T+8
        nCompared++; if (resp_val !== 1'b0) begin nMismatched++; $display("[TB] FAIL load_resp_pulse: got %b expected 0", resp_val); end
    endtask

    // Byte store, immediate ack, ST_ACK four cycles later with an error code.
    task automatic test_store();
        req_val = 1'b1; req_we = 1'b1; req_addr = 40'h00_0000_2003; req_size = 3'd0; req_nc = 1'b1; req_wdata = 64'hDEAD_BEEF_CAFE_005A;
        tick();                                   // T+1
        req_val = 1'b0;
        nCompared++; if (tl_data !== 64'h5A5A_5A5A_5A5A_5A5A) begin nMismatched++; $display("[TB] FAIL store_b_data: got %h expected 5a5a5a5a5a5a5a5a", tl_data); end
        nCompared++; if ({tl_rqtype, tl_nc, tl_size} !== {5'd1, 1'b1, 3'd0}) begin nMismatched++; $display("[TB] FAIL store_b_ctrl: got rq=%h nc=%b size=%0d expected 01/1/0", tl_rqtype, tl_nc, tl_size); end
        l15_ack = 1'b1;
        tick();                                   // T+2
        l15_ack = 1'b0;
        tick(); tick(); tick();                   // T+5
        nCompared++; if (resp_val !== 1'b0) begin nMismatched++; $display("[TB] FAIL store_b_early: got %b expected 0", resp_val); end
        l15_val = 1'b1; l15_rtype = 4'b0100; l15_err = 2'b10;
        l15_data0 = 64'h1234_1234_1234_1234; l15_data1 = 64'h5678_5678_5678_5678;
        sbQ.push_back({64'd0, 2'b10});
        tick();                                   // T+6
        l15_val = 1'b0;
        nCompared++;
        if (resp_val !== 1'b1) begin
            nMismatched++; $display("[TB] FAIL store_b_resp_val: got %b expected 1", resp_val);
        end else if (sbQ.size() == 0) begin
            nMismatched++; $display("[TB] FAIL store_b_sb_empty: got resp with empty scoreboard expected entry");
        end else begin
            sbExp = sbQ.pop_front();
            if ({resp_rdata, resp_err} !== sbExp) begin nMismatched++; $display("[TB] FAIL store_b_rdata: got %h/%b expected %h/%b", resp_rdata, resp_err, sbExp[65:2], sbExp[1:0]); end
        end
        tick();                                   // T+7
        nCompared++; if (resp_val !== 1'b0) begin nMismatched++; $display("[TB] FAIL store_b_once: got %b expected 0", resp_val); end
        nCompared++; if (drop_cnt !== expDrop[7:0]) begin nMismatched++; $display("[TB] FAIL store_b_drop: got %0d expected %0d", drop_cnt, expDrop); end
    endtask

    // An invalidation arriving while waiting is consumed and dropped; the
    // later ST_ACK completes the store.
    task automatic test_inv_drop();
        req_val = 1'b1; req_we = 1'b1; req_addr = 40'h00_0000_3000; req_size = 3'd2; req_nc = 1'b0; req_wdata = 64'hFFFF_0000_1234_5678;
        tick();                                   // T+1
        req_val = 1'b0;
        nCompared++; if (tl_data !== 64'h1234_5678_1234_5678) begin nMismatched++; $display("[TB] FAIL store_w_data: got %h expected 1234567812345678", tl_data); end
        l15_ack = 1'b1;
        tick();                                   // T+2
        l15_ack = 1'b0;
        tick();                                   // T+3
        l15_val = 1'b1; l15_rtype = 4'b0011; l15_err = 2'b00;
        #1;
        nCompared++; if (req_ack !== 1'b1) begin nMismatched++; $display("[TB] FAIL inv_req_ack: got %b expected 1", req_ack); end
        expDrop = (expDrop < 255) ? expDrop + 1 : 255;
        tick();                                   // T+4
        l15_val = 1'b0;
        nCompared++; if (drop_cnt !== expDrop[7:0]) begin nMismatched++; $display("[TB] FAIL inv_drop: got %0d expected %0d", drop_cnt, expDrop); end
        nCompared++; if (resp_val !== 1'b0) begin nMismatched++; $display("[TB] FAIL inv_no_resp: got %b expected 0", resp_val); end
        nCompared++; if (req_rdy !== 1'b0) begin nMismatched++; $display("[TB] FAIL inv_still_busy: got %b expected 0", req_rdy); end
        l15_val = 1'b1; l15_rtype = 4'b0100; l15_err = 2'b01;
        sbQ.push_back({64'd0, 2'b01});
        tick();                                   // T+5
        l15_val = 1'b0;
        nCompared++;
        if (resp_val !== 1'b1) begin
            nMismatched++; $display("[TB] FAIL inv_resp_val: got %b expected 1", resp_val);
        end else if (sbQ.size() == 0) begin
            nMismatched++; $display("[TB] FAIL inv_sb_empty: got resp with empty scoreboard expected entry");
        end else begin
            sbExp = sbQ.pop_front();
            if ({resp_rdata, resp_err} !== sbExp) begin nMismatched++; $display("[TB] FAIL inv_rdata: got %h/%b expected %h/%b", resp_rdata, resp_err, sbExp[65:2], sbExp[1:0]); end
        end
        nCompared++; if (drop_cnt !== expDrop[7:0]) begin nMismatched++; $display("[TB] FAIL inv_drop_after: got %0d expected %0d", drop_cnt, expDrop); end
        tick();
    endtask

    // Ack and LOAD_RET in the same cycle as the request is first presented.
    // The lower 8 bytes are selected for an address with bit 3 clear.
    task automatic test_same_cycle();
        req_val = 1'b1; req_we = 1'b0; req_addr = 40'h00_0000_2000; req_size = 3'd3; req_nc = 1'b0; req_wdata = 64'd0;
        tick();                                   // T+1
        req_val = 1'b0;
        nCompared++; if (tl_val !== 1'b1) begin nMismatched++; $display("[TB] FAIL same_val: got %b expected 1", tl_val); end
        l15_ack = 1'b1; l15_val = 1'b1; l15_rtype = 4'b0000; l15_err = 2'b11;
        l15_data0 = 64'h0F0F_1E1E_2D2D_3C3C; l15_data1 = 64'h9999_8888_7777_6666;
        sbQ.push_back({64'h0F0F_1E1E_2D2D_3C3C, 2'b11});
        tick();                                   // T+2
        l15_ack = 1'b0; l15_val = 1'b0;
        nCompared++;
        if (resp_val !== 1'b1) begin
            nMismatched++; $display("[TB] FAIL same_resp_val: got %b expected 1", resp_val);
        end else if (sbQ.size() == 0) begin
            nMismatched++; $display("[TB] FAIL same_sb_empty: got resp with empty scoreboard expected entry");
        end else begin
            sbExp = sbQ.pop_front();
            if ({resp_rdata, resp_err} !== sbExp) begin nMismatched++; $display("[TB] FAIL same_rdata: got %h/%b expected %h/%b", resp_rdata, resp_err, sbExp[65:2], sbExp[1:0]); end
        end
        nCompared++; if (drop_cnt !== expDrop[7:0]) begin nMismatched++; $display("[TB] FAIL same_drop: got %0d expected %0d", drop_cnt, expDrop); end
        nCompared++; if (tl_val !== 1'b0) begin nMismatched++; $display("[TB] FAIL same_val_off: got %b expected 0", tl_val); end
        tick();
    endtask

    // Two stores back to back: the second is accepted in the completion
    // cycle of the first. Covers the halfword and doubleword data paths.
    task automatic test_back_to_back();
        req_val = 1'b1; req_we = 1'b1; req_addr = 40'h00_0000_4002; req_size = 3'd1; req_nc = 1'b0; req_wdata = 64'h7777_6666_5555_ABCD;
        tick();                                   // T+1
        nCompared++; if (tl_data !== 64'hABCD_ABCD_ABCD_ABCD) begin nMismatched++; $display("[TB] FAIL b2b_h_data: got %h expected abcdabcdabcdabcd", tl_data); end
        req_addr = 40'h00_0000_4008; req_size = 3'd3; req_wdata = 64'h0123_4567_89AB_CDEF;
        l15_ack = 1'b1; l15_val = 1'b1; l15_rtype = 4'b0100; l15_err = 2'b00;
        sbQ.push_back({64'd0, 2'b00});
        tick();                                   // T+2: completion, second accept
        l15_ack = 1'b0; l15_val = 1'b0;
        nCompared++;
        if (resp_val !== 1'b1) begin
            nMismatched++; $display("[TB] FAIL b2b_first_resp: got %b expected 1", resp_val);
        end else if (sbQ.size() == 0) begin
            nMismatched++; $display("[TB] FAIL b2b_sb_empty: got resp with empty scoreboard expected entry");
        end else begin
            sbExp = sbQ.pop_front();
            if ({resp_rdata, resp_err} !== sbExp) begin nMismatched++; $display("[TB] FAIL b2b_first_rdata: got %h/%b expected %h/%b", resp_rdata, resp_err, sbExp[65:2], sbExp[1:0]); end
        end
        nCompared++; if (req_rdy !== 1'b1) begin nMismatched++; $display("[TB] FAIL b2b_rdy: got %b expected 1", req_rdy); end
        tick();                                   // T+3
        req_val = 1'b0;
        nCompared++; if ({tl_val, tl_address, tl_data} !== {1'b1, 40'h00_0000_4008, 64'h0123_4567_89AB_CDEF}) begin nMismatched++; $display("[TB] FAIL b2b_second_req: got val=%b addr=%h data=%h expected 1/4008/0123456789abcdef", tl_val, tl_address, tl_data); end
        nCompared++; if (resp_val !== 1'b0) begin nMismatched++; $display("[TB] FAIL b2b_no_resp: got %b expected 0", resp_val); end
        l15_ack = 1'b1; l15_val = 1'b1; l15_rtype = 4'b0100; l15_err = 2'b01;
        sbQ.push_back({64'd0, 2'b01});
        tick();                                   // T+4
        l15_ack = 1'b0; l15_val = 1'b0;
        nCompared++;
        if (resp_val !== 1'b1) begin
            nMismatched++; $display("[TB] FAIL b2b_second_resp: got %b expected 1", resp_val);
        end else if (sbQ.size() == 0) begin
            nMismatched++; $display("[TB] FAIL b2b_sb_empty2: got resp with empty scoreboard expected entry");
        end else begin
            sbExp = sbQ.pop_front();
            if ({resp_rdata, resp_err} !== sbExp) begin nMismatched++; $display("[TB] FAIL b2b_second_rdata: got %h/%b expected %h/%b", resp_rdata, resp_err, sbExp[65:2], sbExp[1:0]); end
        end
        nCompared++; if (drop_cnt !== expDrop[7:0]) begin nMismatched++; $display("[TB] FAIL b2b_drop: got %0d expected %0d", drop_cnt, expDrop); end
        tick();
    endtask

    // 300 stray responses in IDLE: the counter saturates and ready stays up.
    task automatic test_stray_saturate();
        bit rdyLow;
        int rt;
        rdyLow = 1'b0;
        for (int i = 0; i < 300; i++) begin
            rt = $urandom_range(0, 15);
            l15_val = 1'b1; l15_rtype = rt[3:0];
            tick();
            expDrop = (expDrop < 255) ? expDrop + 1 : 255;
            if (req_rdy !== 1'b1) rdyLow = 1'b1;
        end
        l15_val = 1'b0;
        tick();
        nCompared++; if (drop_cnt !== 8'd255) begin nMismatched++; $display("[TB] FAIL stray_saturate: got %0d expected 255", drop_cnt); end
        nCompared++; if (drop_cnt !== expDrop[7:0]) begin nMismatched++; $display("[TB] FAIL stray_model: got %0d expected %0d", drop_cnt, expDrop); end
        nCompared++; if (rdyLow !== 1'b0) begin nMismatched++; $display("[TB] FAIL stray_rdy: got low at least once expected always 1"); end
        nCompared++; if (resp_val !== 1'b0) begin nMismatched++; $display("[TB] FAIL stray_resp: got %b expected 0", resp_val); end
    endtask

    // Reset asserted mid-cycle while waiting for a response: outputs clear
    // at once, and a late LOAD_RET is then treated as a stray.
    task automatic test_reset_mid();
        req_val = 1'b1; req_we = 1'b0; req_addr = 40'h00_0000_5008; req_size = 3'd3; req_nc = 1'b1; req_wdata = 64'd0;
        tick();                                   // T+1
        req_val = 1'b0;
        l15_ack = 1'b1;
        tick();                                   // T+2, WAIT_RESP
        l15_ack = 1'b0;
        nCompared++; if (req_rdy !== 1'b0) begin nMismatched++; $display("[TB] FAIL rstmid_busy: got %b expected 0", req_rdy); end
        #2;
        rst_n = 1'b0;
        expDrop = 0;
        #1;
        nCompared++; if ({req_rdy, tl_val, resp_val, drop_cnt} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin nMismatched++; $display("[TB] FAIL rstmid_async: got rdy=%b val=%b resp=%b drop=%0d expected 1/0/0/0", req_rdy, tl_val, resp_val, drop_cnt); end
        nCompared++; if ({tl_rqtype, tl_nc, tl_size, tl_address, resp_rdata, resp_err} !== 115'd0) begin nMismatched++; $display("[TB] FAIL rstmid_fields: got addr=%h nc=%b expected 0", tl_address, tl_nc); end
        #1;
        rst_n = 1'b1;
        tick();
        l15_val = 1'b1; l15_rtype = 4'b0000; l15_err = 2'b00;
        l15_data0 = 64'h5555_5555_5555_5555; l15_data1 = 64'h6666_6666_6666_6666;
        expDrop = expDrop + 1;
        tick();
        l15_val = 1'b0;
        nCompared++; if (drop_cnt !== expDrop[7:0]) begin nMismatched++; $display("[TB] FAIL rstmid_drop: got %0d expected %0d", drop_cnt, expDrop); end
        nCompared++; if (resp_val !== 1'b0) begin nMismatched++; $display("[TB] FAIL rstmid_no_resp: got %b expected 0", resp_val); end
        tick();
        nCompared++; if (resp_val !== 1'b0) begin nMismatched++; $display("[TB] FAIL rstmid_no_resp2: got %b expected 0", resp_val); end
    endtask

    // Sequence all scenarios, then confirm every expected completion arrived.
    initial begin
        nCompared = 0; nMismatched = 0; expDrop = 0;
        rst_n = 1'b0; req_val = 1'b0; req_we = 1'b0; req_addr = 40'd0; req_size = 3'd0; req_nc = 1'b0; req_wdata = 64'd0;
        l15_ack = 1'b0; l15_val = 1'b0; l15_rtype = 4'd0; l15_err = 2'd0; l15_data0 = 64'd0; l15_data1 = 64'd0;
        test_reset();
        test_load();
        test_store();
        test_inv_drop();
        test_same_cycle();
        test_back_to_back();
        test_stray_saturate();
        test_reset_mid();
        nCompared++; if (sbQ.size() != 0) begin nMismatched++; $display("[TB] FAIL sb_leftover: got %0d pending expected 0", sbQ.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/l15_simple_transducer.md
# l15_simple_transducer

Single-outstanding request initiator on the core side of the L1.5 transducer interface. Converts a simple valid/ready load/store port into `transducer_l15_*` requests, handles the L1.5 ack, and consumes the `l15_transducer_*` response stream with `transducer_l15_req_ack`. Non-matching responses such as invalidations are acknowledged and discarded. It sits between an accelerator or test master and the L1.5 wrapper in a tile.

## Interface
Parameters:
- DROP_CNT_W, 8, width of the saturating dropped-response counter

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- req_val  in  1  upstream request valid
- req_rdy  out  1  upstream request ready (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_addr  in  40  byte address
- req_size  in  3  L1.5 size code: 0=1B, 1=2B, 2=4B, 3=8B
- req_nc  in  1  non-cacheable
- req_wdata  in  64  store data, right-aligned
- resp_val  out  1  one-cycle completion pulse
- resp_rdata  out  64  load data (store: 0)
- resp_err  out  2  copy of `l15_transducer_error`
- drop_cnt  out  DROP_CNT_W  saturating count of discarded responses
- transducer_l15_val, _rqtype[4:0], _nc, _size[2:0], _address[39:0], _data[63:0]  out  request to L1.5
- transducer_l15_amo_op, _threadid, _prefetch, _invalidate_cacheline, _blockstore, _blockinitstore, _l1rplway, _data_next_entry, _csm_data  out  tied to 0
- l15_transducer_ack  in  1  request accepted
- l15_transducer_val  in  1  response valid
- l15_transducer_returntype  in  4  response type
- l15_transducer_error  in  2  response error
- l15_transducer_data_0, l15_transducer_data_1  in  64  response data, bytes 0–7 and 8–15 of the 16B block
- transducer_l15_req_ack  out  1  response consumed

## Operation
- States: IDLE, REQ, WAIT_RESP.
- **IDLE.** `req_rdy=1`. On `req_val`, register the request and go to REQ.
  - rqtype = `LOAD_RQ` (5'b00000) or `STORE_RQ` (5'b00001).
  - `exp_type` = `LOAD_RET` (4'b0000) or `ST_ACK` (4'b0100).
- **REQ.** `transducer_l15_val=1`; address, size, nc and data are held stable. `l15_transducer_ack=1` goes to WAIT_RESP.
- **WAIT_RESP.** Wait for a response whose returntype equals `exp_type`. On that response:
  - `resp_val` pulses next cycle.
  - `resp_err` is captured.
  - For a load, `resp_rdata` = `addr[3]` ? data_1 : data_0.
  - Return to IDLE.
- **Store data replication.**
  - Size 0: wdata[7:0] repeated ×8.
  - Size 1: wdata[15:0] repeated ×4.
  - Size 2: wdata[31:0] repeated ×2.
  - Size 3: wdata unchanged.
  - Sizes 4–7 are passed unreplicated; this is not a supported use.
- **Load data.** `transducer_l15_data` = 0.
- **Response consumption.**
  - `transducer_l15_req_ack` = `l15_transducer_val`, combinationally, in every state: every response is consumed in the cycle it appears.
  - A response that does not complete a request increments `drop_cnt`, saturating at all-ones. This covers: arrival in IDLE, arrival in REQ without same-cycle ack, and a returntype mismatch.
- **Ack and matching response in the same cycle (REQ).** Treated as completion: resp_val next cycle, go to IDLE, no drop.
- **Reset** (any state, mid-transaction included): state IDLE. The outstanding request is abandoned with no resp_val.

## Timing
- **Reset values:**
  - `req_rdy=1`
  - `transducer_l15_val=0`
  - `resp_val=0`, `resp_rdata=0`, `resp_err=0`
  - `drop_cnt=0`
  - all `transducer_l15_*` data/control outputs = 0
- **Request path.** Accept at cycle T (req_val & req_rdy) → `transducer_l15_val=1` from T+1 until the ack cycle A inclusive → 0 at A+1.
- **Completion.** Matching response at cycle M → `resp_val=1` and data valid in M+1 only → `req_rdy=1` at M+1. New accept possible at M+1.
- **Minimum latency.** Accept to resp_val is 2 cycles, via same-cycle ack+response at T+1.
- **Output timing.** All outputs are registered except `transducer_l15_req_ack`.

## Test plan
- Load 8B at 0x0000_1008, ack at T+3, LOAD_RET at T+6 with data_0=0x1111…, data_1=0xAAAA_BBBB_CCCC_DDDD:
  - rqtype=0 and val high exactly T+1..T+3.
  - resp_val at T+7 with rdata=0xAAAA_BBBB_CCCC_DDDD.
- Store size 0 of wdata=0x5A, immediate ack, ST_ACK 4 cycles later:
  - data=0x5A5A_5A5A_5A5A_5A5A, rqtype=1.
  - resp_val once, rdata=0.
- INV_RET (4'b0011) arrives in WAIT_RESP before ST_ACK:
  - req_ack high that cycle, drop_cnt=1, no resp_val.
  - Completion occurs on the later ST_ACK.
- 300 stray responses in IDLE: drop_cnt saturates at 255, req_rdy stays 1.
- Ack and LOAD_RET in the same cycle at T+1: resp_val at T+2, drop_cnt unchanged.
- rst_n asserted in WAIT_RESP:
  - All outputs return to reset values asynchronously.
  - A later LOAD_RET is dropped, drop_cnt=1, no resp_val.
